// File: rtl/req_arbiter_8_if.sv
// Request/grant bundle shared by the 8-client arbiter and its clients.
// The master side (clients) drives requests; the slave side (arbiter) drives grants.
interface req_arbiter_8_if;
    logic       en;
    logic       mode;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       gnt_valid;
    logic       timeout_pulse;

    modport master (
        output en, mode, req,
        input  gnt, gnt_id, gnt_valid, timeout_pulse
    );

    modport slave (
        input  en, mode, req,
        output gnt, gnt_id, gnt_valid, timeout_pulse
    );
endinterface

// File: rtl/req_arbiter_8.sv
// Eight-client req/gnt arbiter: fixed-priority (highest index) or round-robin selection,
// grant held until release or hold timeout, with registered one-hot and encoded grant outputs.
module req_arbiter_8 #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    req_arbiter_8_if.slave   bus
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);
    localparam logic       TIMEOUT_EN  = (TIMEOUT != 0);

    state_t     state_q, state_d;
    logic [7:0] gnt_q, gnt_d;
    logic [2:0] gnt_id_q, gnt_id_d;
    logic       gnt_valid_q, gnt_valid_d;
    logic       timeout_pulse_q, timeout_pulse_d;
    logic [7:0] hold_cnt_q, hold_cnt_d;
    logic [2:0] last_id_q, last_id_d;

    logic [2:0] winner;
    logic       req_held;
    logic       timeout_hit;

    // Highest set bit wins; scanning upward lets later (higher) bits overwrite.
    function automatic logic [2:0] fixed_pick(input logic [7:0] r);
        logic [2:0] res;
        res = '0;
        for (int i = 0; i < 8; i++) begin
            if (r[i]) res = 3'(i);
        end
        return res;
    endfunction

    // First set bit starting just above the last winner, wrapping 7 -> 0.
    function automatic logic [2:0] rr_pick(input logic [7:0] r, input logic [2:0] last);
        logic [2:0] res;
        logic [2:0] idx;
        logic       found;
        res   = '0;
        found = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            idx = last + 3'(i);
            if (!found && r[idx]) begin
                res   = idx;
                found = 1'b1;
            end
        end
        return res;
    endfunction

    always_comb begin
        winner      = bus.mode ? rr_pick(bus.req, last_id_q) : fixed_pick(bus.req);
        req_held    = bus.req[gnt_id_q];
        timeout_hit = TIMEOUT_EN && (hold_cnt_q == TIMEOUT_CNT);

        state_d         = state_q;
        gnt_d           = gnt_q;
        gnt_id_d        = gnt_id_q;
        gnt_valid_d     = gnt_valid_q;
        timeout_pulse_d = 1'b0;
        hold_cnt_d      = hold_cnt_q;
        last_id_d       = last_id_q;

        case (state_q)
            IDLE: begin
                gnt_d       = '0;
                gnt_valid_d = 1'b0;
                if (bus.en && (bus.req != 8'h00)) begin
                    gnt_d       = 8'b1 << winner;
                    gnt_id_d    = winner;
                    gnt_valid_d = 1'b1;
                    hold_cnt_d  = 8'd1;
                    state_d     = GRANT;
                end
            end
            GRANT: begin
                if (!req_held || !bus.en || timeout_hit) begin
                    gnt_d       = '0;
                    gnt_valid_d = 1'b0;
                    last_id_d   = gnt_id_q;
                    hold_cnt_d  = '0;
                    state_d     = IDLE;
                    // Only a pure timeout is flagged; a drop or disable on the same edge wins.
                    timeout_pulse_d = timeout_hit && req_held && bus.en;
                end else begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d     = IDLE;
                gnt_d       = '0;
                gnt_valid_d = 1'b0;
                hold_cnt_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            gnt_q           <= '0;
            gnt_id_q        <= '0;
            gnt_valid_q     <= 1'b0;
            timeout_pulse_q <= 1'b0;
            hold_cnt_q      <= '0;
            last_id_q       <= 3'd7;
        end else begin
            state_q         <= state_d;
            gnt_q           <= gnt_d;
            gnt_id_q        <= gnt_id_d;
            gnt_valid_q     <= gnt_valid_d;
            timeout_pulse_q <= timeout_pulse_d;
            hold_cnt_q      <= hold_cnt_d;
            last_id_q       <= last_id_d;
        end
    end

    assign bus.gnt           = gnt_q;
    assign bus.gnt_id        = gnt_id_q;
    assign bus.gnt_valid     = gnt_valid_q;
    assign bus.timeout_pulse = timeout_pulse_q;

endmodule

// File: tb/tb_req_arbiter_8.sv
// Bench for req_arbiter_8: three instances (TIMEOUT 4, 2, 0) sharing one stimulus,
// directed scenarios plus randomized traffic against a grant-level reference model.
module tb_req_arbiter_8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       mode = 1'b0;
    logic [7:0] req = 8'h00;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    req_arbiter_8_if if0 ();
    req_arbiter_8_if if1 ();
    req_arbiter_8_if if2 ();

    assign if0.en = en;  assign if0.mode = mode;  assign if0.req = req;
    assign if1.en = en;  assign if1.mode = mode;  assign if1.req = req;
    assign if2.en = en;  assign if2.mode = mode;  assign if2.req = req;

    req_arbiter_8 #(.TIMEOUT(4)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    req_arbiter_8 #(.TIMEOUT(2)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    req_arbiter_8 #(.TIMEOUT(0)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

    logic [7:0] o_gnt [3];
    logic [2:0] o_id  [3];
    logic       o_vld [3];
    logic       o_tp  [3];

    assign o_gnt[0] = if0.gnt; assign o_id[0] = if0.gnt_id; assign o_vld[0] = if0.gnt_valid; assign o_tp[0] = if0.timeout_pulse;
    assign o_gnt[1] = if1.gnt; assign o_id[1] = if1.gnt_id; assign o_vld[1] = if1.gnt_valid; assign o_tp[1] = if1.timeout_pulse;
    assign o_gnt[2] = if2.gnt; assign o_id[2] = if2.gnt_id; assign o_vld[2] = if2.gnt_valid; assign o_tp[2] = if2.timeout_pulse;

    // Reference model: who holds the resource (-1 = nobody), for how long, and who held it last.
    int m_to   [3] = '{4, 2, 0};
    int m_cur  [3] = '{-1, -1, -1};
    int m_held [3] = '{0, 0, 0};
    int m_last [3] = '{7, 7, 7};
    int m_id   [3] = '{0, 0, 0};
    bit m_tp   [3] = '{0, 0, 0};

    always @(posedge clk) begin
        for (int d = 0; d < 3; d++) begin
            m_tp[d] = 1'b0;
            if (!rst_n) begin
                m_cur[d] = -1; m_held[d] = 0; m_last[d] = 7; m_id[d] = 0;
            end else if (m_cur[d] < 0) begin
                if (en && req != 8'h00) begin
                    int w;
                    w = -1;
                    if (!mode) begin
                        for (int i = 7; i >= 0; i--) if (w < 0 && req[i]) w = i;
                    end else begin
                        for (int k = 1; k <= 8; k++) if (w < 0 && req[(m_last[d] + k) % 8]) w = (m_last[d] + k) % 8;
                    end
                    m_cur[d] = w; m_id[d] = w; m_held[d] = 1;
                end
            end else begin
                bool_release(d);
            end
        end
    end

    task automatic bool_release(input int d);
        bit still, expired;
        still   = req[m_cur[d]] && en;
        expired = (m_to[d] != 0) && (m_held[d] >= m_to[d]);
        if (!still || expired) begin
            m_tp[d]   = still && expired;
            m_last[d] = m_cur[d];
            m_cur[d]  = -1;
            m_held[d] = 0;
        end else begin
            m_held[d]++;
        end
    endtask

    task automatic drive(input logic e, input logic m, input logic [7:0] r);
        en = e; mode = m; req = r;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b1, 1'b0, 8'hFF);
        drive(1'b1, 1'b1, 8'hFF);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (o_gnt[d] !== 8'h00 || o_id[d] !== 3'd0 || o_vld[d] !== 1'b0 || o_tp[d] !== 1'b0) begin
                failures++;
                $display("FAIL reset dut%0d: gnt=%h id=%0d vld=%b tp=%b, want all 0", d, o_gnt[d], o_id[d], o_vld[d], o_tp[d]);
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_fixed_priority();
        drive(1'b1, 1'b0, 8'b0010_0110);
        checks++;
        if (o_gnt[0] !== 8'h20 || o_id[0] !== 3'd5 || o_vld[0] !== 1'b1) begin
            failures++;
            $display("FAIL fixed_first: gnt=%h id=%0d vld=%b, want 20/5/1", o_gnt[0], o_id[0], o_vld[0]);
        end
        drive(1'b1, 1'b0, 8'b0000_0110);
        checks++;
        if (o_gnt[0] !== 8'h00 || o_vld[0] !== 1'b0) begin
            failures++;
            $display("FAIL fixed_gap: gnt=%h vld=%b, want 00/0", o_gnt[0], o_vld[0]);
        end
        drive(1'b1, 1'b0, 8'b0000_0110);
        checks++;
        if (o_gnt[0] !== 8'h04 || o_id[0] !== 3'd2) begin
            failures++;
            $display("FAIL fixed_second: gnt=%h id=%0d, want 04/2", o_gnt[0], o_id[0]);
        end
        drive(1'b1, 1'b0, 8'h00);
        drive(1'b1, 1'b0, 8'h00);
    endtask

    task automatic test_round_robin();
        logic [7:0] onehot;
        rst_n = 1'b0;
        drive(1'b0, 1'b1, 8'h00);
        rst_n = 1'b1;
        for (int g = 0; g < 9; g++) begin
            onehot = 8'b1 << (g % 8);
            drive(1'b1, 1'b1, 8'hFF);
            checks++;
            if (o_gnt[0] !== onehot || o_id[0] !== 3'(g % 8) || o_vld[0] !== 1'b1) begin
                failures++;
                $display("FAIL rr_grant%0d: gnt=%h id=%0d, want %h/%0d", g, o_gnt[0], o_id[0], onehot, g % 8);
            end
            drive(1'b1, 1'b1, 8'hFF);
            drive(1'b1, 1'b1, 8'hFF);
            checks++;
            if (o_gnt[0] !== onehot) begin
                failures++;
                $display("FAIL rr_hold%0d: gnt=%h, want %h", g, o_gnt[0], onehot);
            end
            drive(1'b1, 1'b1, 8'hFF & ~onehot);
            checks++;
            if (o_gnt[0] !== 8'h00 || o_vld[0] !== 1'b0) begin
                failures++;
                $display("FAIL rr_release%0d: gnt=%h vld=%b, want 00/0", g, o_gnt[0], o_vld[0]);
            end
        end
    endtask

    task automatic test_timeout();
        drive(1'b1, 1'b0, 8'h00);
        for (int c = 1; c <= 4; c++) begin
            drive(1'b1, 1'b0, 8'h01);
            checks++;
            if (o_gnt[0] !== 8'h01 || o_tp[0] !== 1'b0 || o_gnt[2] !== 8'h01) begin
                failures++;
                $display("FAIL timeout_hold%0d: gnt0=%h tp0=%b gnt2=%h, want 01/0/01", c, o_gnt[0], o_tp[0], o_gnt[2]);
            end
        end
        drive(1'b1, 1'b0, 8'h01);
        checks++;
        if (o_gnt[0] !== 8'h00 || o_tp[0] !== 1'b1 || o_gnt[2] !== 8'h01 || o_tp[2] !== 1'b0) begin
            failures++;
            $display("FAIL timeout_fire: gnt0=%h tp0=%b gnt2=%h tp2=%b, want 00/1/01/0", o_gnt[0], o_tp[0], o_gnt[2], o_tp[2]);
        end
        drive(1'b1, 1'b0, 8'h01);
        checks++;
        if (o_gnt[0] !== 8'h01 || o_tp[0] !== 1'b0) begin
            failures++;
            $display("FAIL timeout_regrant: gnt=%h tp=%b, want 01/0", o_gnt[0], o_tp[0]);
        end
        drive(1'b1, 1'b0, 8'h00);
    endtask

    task automatic test_enable();
        for (int c = 0; c < 3; c++) begin
            drive(1'b0, 1'b0, 8'hFF);
            for (int d = 0; d < 3; d++) begin
                checks++;
                if (o_gnt[d] !== 8'h00 || o_vld[d] !== 1'b0) begin
                    failures++;
                    $display("FAIL en_low dut%0d: gnt=%h vld=%b, want 00/0", d, o_gnt[d], o_vld[d]);
                end
            end
        end
        drive(1'b1, 1'b0, 8'hFF);
        checks++;
        if (o_gnt[0] !== 8'h80 || o_id[0] !== 3'd7) begin
            failures++;
            $display("FAIL en_grant: gnt=%h id=%0d, want 80/7", o_gnt[0], o_id[0]);
        end
        drive(1'b1, 1'b0, 8'hFF);
        drive(1'b0, 1'b0, 8'hFF);
        // dut1 reaches its timeout on this same edge; the disable must suppress the pulse.
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (o_gnt[d] !== 8'h00 || o_tp[d] !== 1'b0) begin
                failures++;
                $display("FAIL en_drop dut%0d: gnt=%h tp=%b, want 00/0", d, o_gnt[d], o_tp[d]);
            end
        end
        drive(1'b1, 1'b0, 8'h00);
    endtask

    task automatic test_reset_mid_grant();
        drive(1'b1, 1'b1, 8'h01);
        drive(1'b1, 1'b1, 8'h00);
        drive(1'b1, 1'b0, 8'h80);
        checks++;
        if (o_gnt[0] !== 8'h80) begin
            failures++;
            $display("FAIL rstmid_setup: gnt=%h, want 80", o_gnt[0]);
        end
        rst_n = 1'b0;
        drive(1'b1, 1'b0, 8'h80);
        checks++;
        if (o_gnt[0] !== 8'h00 || o_id[0] !== 3'd0 || o_vld[0] !== 1'b0 || o_tp[0] !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_clear: gnt=%h id=%0d vld=%b tp=%b, want 00/0/0/0", o_gnt[0], o_id[0], o_vld[0], o_tp[0]);
        end
        rst_n = 1'b1;
        drive(1'b1, 1'b1, 8'h81);
        checks++;
        if (o_gnt[0] !== 8'h01 || o_id[0] !== 3'd0) begin
            failures++;
            $display("FAIL rstmid_rr: gnt=%h id=%0d, want 01/0", o_gnt[0], o_id[0]);
        end
        drive(1'b1, 1'b1, 8'h00);
        drive(1'b1, 1'b0, 8'h00);
    endtask

    task automatic test_edge_coincidence();
        drive(1'b1, 1'b0, 8'h08);
        drive(1'b1, 1'b0, 8'h08);
        checks++;
        if (o_gnt[1] !== 8'h08) begin
            failures++;
            $display("FAIL coinc_hold: gnt=%h, want 08", o_gnt[1]);
        end
        drive(1'b1, 1'b0, 8'h00);
        checks++;
        if (o_gnt[1] !== 8'h00 || o_tp[1] !== 1'b0) begin
            failures++;
            $display("FAIL coinc_drop: gnt=%h tp=%b, want 00/0", o_gnt[1], o_tp[1]);
        end
        drive(1'b1, 1'b0, 8'h08);
        drive(1'b1, 1'b0, 8'h08);
        drive(1'b1, 1'b0, 8'h08);
        checks++;
        if (o_gnt[1] !== 8'h00 || o_tp[1] !== 1'b1) begin
            failures++;
            $display("FAIL coinc_timeout: gnt=%h tp=%b, want 00/1", o_gnt[1], o_tp[1]);
        end
        drive(1'b1, 1'b0, 8'h00);
        drive(1'b1, 1'b0, 8'h00);
    endtask

    task automatic test_random();
        logic [7:0] r;
        logic       m;
        logic [7:0] exp_gnt;
        r = 8'h00;
        m = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            rst_n = ($urandom_range(0, 79) != 0);
            if ($urandom_range(0, 19) == 0) m = ~m;
            if ($urandom_range(0, 2) == 0) r[$urandom_range(0, 7)] ^= 1'b1;
            if ($urandom_range(0, 39) == 0) r = 8'($urandom);
            drive(($urandom_range(0, 15) != 0), m, r);
            for (int d = 0; d < 3; d++) begin
                exp_gnt = (m_cur[d] >= 0) ? (8'b1 << m_cur[d]) : 8'h00;
                checks++;
                if (o_gnt[d] !== exp_gnt || o_id[d] !== 3'(m_id[d]) ||
                    o_vld[d] !== (m_cur[d] >= 0) || o_tp[d] !== m_tp[d]) begin
                    failures++;
                    $display("FAIL random c%0d dut%0d: gnt=%h id=%0d vld=%b tp=%b, want %h/%0d/%b/%b",
                             c, d, o_gnt[d], o_id[d], o_vld[d], o_tp[d],
                             exp_gnt, m_id[d], (m_cur[d] >= 0), m_tp[d]);
                end
            end
        end
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_fixed_priority();
        test_round_robin();
        test_timeout();
        test_enable();
        test_reset_mid_grant();
        test_edge_coincidence();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
